register_scoreboard_ctr: RTL

Parametrised register scoreboard for the pipelined LC-3b core. It sits between decode/issue and writeback and tracks outstanding writes to each architectural register. Each register has a saturating pending-write counter instead of a single valid bit, so several writes to the same register can be in flight at once. It adds multiple writeback ports, source-operand readiness lookups, a pipeline-flush clear and a sticky underflow error.

---
 rtl/register_scoreboard_ctr_pkg.sv | 22 ++
 rtl/register_scoreboard_ctr_counter.sv | 58 +++++
 rtl/register_scoreboard_ctr.sv | 119 +++++++++++
 3 files changed

// File: rtl/register_scoreboard_ctr_pkg.sv
// -----------------------------------------------------------------------------
// lc3b_types : shared types and default constants for the LC-3b core.
//
// Provides the register scoreboard defaults (SB_NUM_REGS, SB_CNT_W, SB_NUM_WB),
// the pending-counter type sb_cnt_t and the architectural register index type
// lc3b_reg used by the default configuration.
// -----------------------------------------------------------------------------
package lc3b_types;

  localparam int SB_NUM_REGS = 8;
  localparam int SB_CNT_W    = 2;
  localparam int SB_NUM_WB   = 2;

  typedef logic [SB_CNT_W-1:0]           sb_cnt_t;
  typedef logic [$clog2(SB_NUM_REGS)-1:0] lc3b_reg;

  // Width needed to hold a count of 0..n.
  function automatic int sb_count_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/register_scoreboard_ctr_counter.sv
// -----------------------------------------------------------------------------
// scoreboard_counter : per-register saturating pending-write counter.
//
// Ports:
//   clk         in   clock
//   rst         in   synchronous active-high reset
//   inc_i       in   one write issued to this register this cycle
//   dec_i       in   number of writebacks retiring to this register this cycle
//   flush_i     in   clear the counter (overrides inc/dec)
//   count_o     out  registered pending-write count
//   underflow_o out  this cycle's writebacks exceed count + inc (comb.)
// -----------------------------------------------------------------------------
module scoreboard_counter
  import lc3b_types::*;
#(
  parameter int CNT_W = SB_CNT_W,
  parameter int DW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic [DW-1:0]    dec_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] count_o,
  output logic             underflow_o
);

  // Wide enough for count + inc and for the decrement without wrapping.
  localparam int SW = ((CNT_W + 1) > DW) ? (CNT_W + 1) : DW;

  logic [CNT_W-1:0] count_q, count_d;
  logic [SW-1:0]    avail, dec_w, net;

  always_comb begin
    count_d     = count_q;
    underflow_o = 1'b0;
    avail       = SW'(count_q) + SW'(inc_i);
    dec_w       = SW'(dec_i);
    net         = avail - dec_w;
    if (flush_i) begin
      count_d = '0;
    end else if (dec_w > avail) begin
      count_d     = '0;
      underflow_o = 1'b1;
    end else begin
      // inc is only granted below CNT_MAX, so net always fits in CNT_W bits.
      count_d = net[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/register_scoreboard_ctr.sv
// -----------------------------------------------------------------------------
// register_scoreboard_ctr : pending-write scoreboard between issue and
// writeback. Each register keeps a saturating count of outstanding writes.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   issue_valid/hold/dest    issue request, stall, destination
//   issue_ready              destination counter not saturated
//   src_a/src_b              source registers checked at decode
//   src_a_ready/src_b_ready  source has no pending write
//   wb_valid/wb_dest         per-port writeback strobes and destinations
//   flush                    clear all counters
//   ready_vec                bit i set when register i has nothing pending
//   underflow_err            sticky: writebacks exceeded pending writes
//
// Build option: SCOREBOARD_WB_BYPASS_EN lets src_x_ready see same-cycle
// writebacks that retire every pending write of src_x.
// -----------------------------------------------------------------------------
module register_scoreboard_ctr
  import lc3b_types::*;
#(
  parameter int NUM_REGS = SB_NUM_REGS,
  parameter int CNT_W    = SB_CNT_W,
  parameter int NUM_WB   = SB_NUM_WB,
  localparam int IW      = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  input  logic                 issue_hold,
  input  logic [IW-1:0]        issue_dest,
  output logic                 issue_ready,
  input  logic [IW-1:0]        src_a,
  input  logic [IW-1:0]        src_b,
  output logic                 src_a_ready,
  output logic                 src_b_ready,
  input  logic [NUM_WB-1:0]    wb_valid,
  input  logic [NUM_WB*IW-1:0] wb_dest,
  input  logic                 flush,
  output logic [NUM_REGS-1:0]  ready_vec,
  output logic                 underflow_err
);

  localparam int DW = sb_count_width(NUM_WB);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]    cnt     [NUM_REGS];
  logic [DW-1:0]       dec_arr [NUM_REGS];
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] uf_vec;
  logic                issue_fire;
  logic                err_q, err_d;
  logic                flush_q;

  assign issue_ready = (cnt[issue_dest] != CNT_MAX);
  assign issue_fire  = issue_valid & ~issue_hold & issue_ready;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      inc_vec[i] = issue_fire && (issue_dest == IW'(i));
      dec_arr[i] = '0;
      for (int k = 0; k < NUM_WB; k++) begin
        if (wb_valid[k] && (wb_dest[k*IW +: IW] == IW'(i)))
          dec_arr[i] = dec_arr[i] + DW'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
    scoreboard_counter #(
      .CNT_W (CNT_W),
      .DW    (DW)
    ) u_cnt (
      .clk         (clk),
      .rst         (rst),
      .inc_i       (inc_vec[g]),
      .dec_i       (dec_arr[g]),
      .flush_i     (flush),
      .count_o     (cnt[g]),
      .underflow_o (uf_vec[g])
    );
    assign ready_vec[g] = (cnt[g] == '0);
  end

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam int CW = (CNT_W > DW) ? CNT_W : DW;

  always_comb begin
    src_a_ready = (cnt[src_a] == '0);
    src_b_ready = (cnt[src_b] == '0);
    // Forward when this cycle's writebacks drain every pending write and
    // no new write to the same register is being issued alongside them.
    if (!inc_vec[src_a] && (CW'(cnt[src_a]) == CW'(dec_arr[src_a])))
      src_a_ready = 1'b1;
    if (!inc_vec[src_b] && (CW'(cnt[src_b]) == CW'(dec_arr[src_b])))
      src_b_ready = 1'b1;
  end
`else
  assign src_a_ready = (cnt[src_a] == '0);
  assign src_b_ready = (cnt[src_b] == '0);
`endif

  // Stale writebacks in the cycle right after a flush are expected and must
  // not be reported; counters still clamp them at zero.
  assign err_d = err_q | ((|uf_vec) & ~flush_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q   <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      err_q   <= err_d;
      flush_q <= flush;
    end
  end

  assign underflow_err = err_q;

endmodule
